// File: rtl/pc_sequencer.sv
// pc_sequencer: control FSM driving the program-counter register of the
// accumulator core. Issues instruction fetches, waits for the memory
// handshake (with a fetch timeout), then spends exactly one EXEC cycle
// turning decoded control into PC increment/load strobes.
//
// Optional feature macro: CALL_STACK_EN
//   defined   -> STACK_DEPTH-entry return-address stack for call/return;
//                overflow/underflow sends the FSM to ERROR.
//   undefined -> no storage; dec_call acts as an unconditional branch and
//                dec_ret is ignored.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             leave IDLE and begin fetching
//   pc                current PC register value (return-address source)
//   instr_valid       fetch response for the outstanding request
//   dec_*             decoded control of the instruction in EXEC
//   zero              ALU zero flag (for branch-if-zero)
//   dec_target        branch/call target, zero-extended to PC_W
//   fetch_req         fetch outstanding (asserted throughout FETCH)
//   pc_inc, pc_load   PC update strobes, mutually exclusive
//   pc_target         load value, 0 whenever pc_load is low
//   halted, err       FSM parked in HALTED / ERROR
//   retired           saturating retired-instruction count
module pc_sequencer #(
  parameter int unsigned PC_W        = 7,
  parameter int unsigned TGT_W       = 6,
  parameter int unsigned TIMEOUT     = 16,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  pc,
  input  logic             instr_valid,
  input  logic             dec_halt,
  input  logic             dec_br_zero,
  input  logic             dec_br_always,
  input  logic             dec_call,
  input  logic             dec_ret,
  input  logic             zero,
  input  logic [TGT_W-1:0] dec_target,
  output logic             fetch_req,
  output logic             pc_inc,
  output logic             pc_load,
  output logic [PC_W-1:0]  pc_target,
  output logic             halted,
  output logic             err,
  output logic [15:0]      retired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_HALTED, S_ERROR} state_t;
  typedef enum logic [2:0] {A_INC, A_BRANCH, A_CALL, A_RET, A_HALT, A_FAULT} act_t;

  state_t            state, next_state;
  act_t              act;
  logic [CNT_W-1:0]  wait_cnt;
  logic [PC_W-1:0]   tgt_ext;
  logic [PC_W-1:0]   ret_target;
  logic              stack_empty;
  logic              stack_full;

  assign tgt_ext = PC_W'(dec_target);

`ifdef CALL_STACK_EN
  localparam int unsigned SP_W = $clog2(STACK_DEPTH + 1);

  logic [PC_W-1:0] stack_mem [STACK_DEPTH];
  logic [SP_W-1:0] sp;
  logic [PC_W-1:0] ret_addr;

  assign stack_empty = (sp == '0);
  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  // Return address wraps within PC_W bits (top of memory returns to 0).
  assign ret_addr    = pc + PC_W'(1);

  always_comb begin
    ret_target = '0;
    for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
      if (sp == SP_W'(i + 1)) ret_target = stack_mem[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp <= '0;
    end else if (state == S_EXEC) begin
      case (act)
        A_CALL: begin
          for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
            if (sp == SP_W'(i)) stack_mem[i] <= ret_addr;
          end
          sp <= sp + SP_W'(1);
        end
        A_RET:   sp <= sp - SP_W'(1);
        default: ;
      endcase
    end
  end
`else
  logic unused_inputs;

  assign stack_empty   = 1'b0;
  assign stack_full    = 1'b0;
  assign ret_target    = '0;
  assign unused_inputs = ^{pc, dec_ret, stack_empty, stack_full};
`endif

  // Decode priority for the EXEC cycle: halt > ret > call > branch > inc.
  always_comb begin
    act = A_INC;
    if (dec_halt) begin
      act = A_HALT;
`ifdef CALL_STACK_EN
    end else if (dec_ret) begin
      act = stack_empty ? A_FAULT : A_RET;
    end else if (dec_call) begin
      act = stack_full ? A_FAULT : A_CALL;
`else
    end else if (dec_call) begin
      act = A_BRANCH;
`endif
    end else if (dec_br_always || (dec_br_zero && zero)) begin
      act = A_BRANCH;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_FETCH;
      S_FETCH: begin
        if (instr_valid)                          next_state = S_EXEC;
        else if (wait_cnt == CNT_W'(TIMEOUT - 1)) next_state = S_ERROR;
      end
      S_EXEC: begin
        case (act)
          A_HALT:  next_state = S_HALTED;
          A_FAULT: next_state = S_ERROR;
          default: next_state = S_FETCH;
        endcase
      end
      S_HALTED: next_state = S_HALTED;
      S_ERROR:  next_state = S_ERROR;
      default:  next_state = S_IDLE;
    endcase
  end

  always_comb begin
    fetch_req = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    pc_target = '0;
    halted    = 1'b0;
    err       = 1'b0;
    case (state)
      S_FETCH:  fetch_req = 1'b1;
      S_EXEC: begin
        case (act)
          A_INC:            pc_inc = 1'b1;
          A_BRANCH, A_CALL: begin
            pc_load   = 1'b1;
            pc_target = tgt_ext;
          end
          A_RET: begin
            pc_load   = 1'b1;
            pc_target = ret_target;
          end
          default: ;
        endcase
      end
      S_HALTED: halted = 1'b1;
      S_ERROR:  err    = 1'b1;
      default:  ;
    endcase
  end

  // Wait counter only runs while staying in FETCH, so every FETCH entry
  // starts from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
      retired  <= '0;
    end else begin
      if (state == S_FETCH && next_state == S_FETCH) wait_cnt <= wait_cnt + CNT_W'(1);
      else                                           wait_cnt <= '0;
      if (state == S_EXEC && act != A_FAULT && retired != '1) retired <= retired + 16'd1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam int unsigned PC_W        = 7;
  localparam int unsigned TGT_W       = 6;
  localparam int unsigned TIMEOUT     = 16;
  localparam int unsigned STACK_DEPTH = 4;

  localparam int P_IDLE = 0, P_FETCH = 1, P_EXEC = 2, P_HALTED = 3, P_ERROR = 4;
  localparam int K_HALT = 0, K_INC = 1, K_LOAD = 2, K_SERR = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [PC_W-1:0]  pc = '0;
  logic             instr_valid = 1'b0;
  logic             dec_halt = 1'b0, dec_br_zero = 1'b0, dec_br_always = 1'b0;
  logic             dec_call = 1'b0, dec_ret = 1'b0, zero = 1'b0;
  logic [TGT_W-1:0] dec_target = '0;
  logic             fetch_req, pc_inc, pc_load, halted, err;
  logic [PC_W-1:0]  pc_target;
  logic [15:0]      retired;

  pc_sequencer #(
    .PC_W(PC_W), .TGT_W(TGT_W), .TIMEOUT(TIMEOUT), .STACK_DEPTH(STACK_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pc(pc), .instr_valid(instr_valid),
    .dec_halt(dec_halt), .dec_br_zero(dec_br_zero), .dec_br_always(dec_br_always),
    .dec_call(dec_call), .dec_ret(dec_ret), .zero(zero), .dec_target(dec_target),
    .fetch_req(fetch_req), .pc_inc(pc_inc), .pc_load(pc_load), .pc_target(pc_target),
    .halted(halted), .err(err), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        fetch_req, pc_inc, pc_load;
    logic [6:0]  pc_target;
    logic        halted, err;
    logic [15:0] retired;
  } outs_t;

  typedef struct packed {
    logic       brz, bra, zf;
    logic [5:0] tgt;
    logic       exp_inc, exp_load;
    logic [6:0] exp_tgt;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural reference: phase, cycles spent waiting, retired count, return stack.
  int         m_phase   = P_IDLE;
  int         m_waited  = 0;
  int         m_retired = 0;
  logic [6:0] m_stack[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exec_kind();
    if (dec_halt) return K_HALT;
`ifdef CALL_STACK_EN
    if (dec_ret)  return (m_stack.size() == 0) ? K_SERR : K_LOAD;
    if (dec_call) return (m_stack.size() >= STACK_DEPTH) ? K_SERR : K_LOAD;
`else
    if (dec_call) return K_LOAD;
`endif
    if (dec_br_always || (dec_br_zero && zero)) return K_LOAD;
    return K_INC;
  endfunction

  function automatic logic [6:0] exec_target();
`ifdef CALL_STACK_EN
    if (dec_ret) return m_stack[$];
`endif
    return {1'b0, dec_target};
  endfunction

  function automatic outs_t model_out();
    outs_t o = '0;
    o.fetch_req = (m_phase == P_FETCH);
    o.halted    = (m_phase == P_HALTED);
    o.err       = (m_phase == P_ERROR);
    o.retired   = m_retired[15:0];
    if (m_phase == P_EXEC) begin
      if (exec_kind() == K_INC) o.pc_inc = 1'b1;
      if (exec_kind() == K_LOAD) begin
        o.pc_load   = 1'b1;
        o.pc_target = exec_target();
      end
    end
    return o;
  endfunction

  task automatic model_update();
    int k;
    if (reset) begin
      m_phase = P_IDLE; m_waited = 0; m_retired = 0; m_stack.delete();
      return;
    end
    case (m_phase)
      P_IDLE:  if (start) begin m_phase = P_FETCH; m_waited = 0; end
      P_FETCH: begin
        if (instr_valid) m_phase = P_EXEC;
        else begin
          m_waited++;
          if (m_waited >= TIMEOUT) m_phase = P_ERROR;
        end
      end
      P_EXEC: begin
        k = exec_kind();
        if (k == K_SERR) m_phase = P_ERROR;
        else begin
          if (m_retired < 65535) m_retired++;
          m_phase  = (k == K_HALT) ? P_HALTED : P_FETCH;
          m_waited = 0;
`ifdef CALL_STACK_EN
          if (k != K_HALT) begin
            if (dec_ret)       void'(m_stack.pop_back());
            else if (dec_call) m_stack.push_back(pc + 7'd1);
          end
`endif
        end
      end
      default: ;
    endcase
  endtask

  function automatic outs_t dut_out();
    return {fetch_req, pc_inc, pc_load, pc_target, halted, err, retired};
  endfunction

  // Called at a negedge with inputs applied; checks, clocks, returns at next negedge.
  task automatic step();
    #1;
    chk("cycle_outputs", 32'(dut_out()), 32'(model_out()));
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic clear_dec();
    dec_halt = 0; dec_br_zero = 0; dec_br_always = 0; dec_call = 0; dec_ret = 0;
    zero = 0; dec_target = '0;
  endtask

  task automatic do_reset();
    reset = 1; start = 0; instr_valid = 0; clear_dec();
    step();
    reset = 0;
  endtask

  task automatic start_and_fetch();
    start = 1; step(); start = 0;
  endtask

  task automatic issue();
    instr_valid = 1; step(); instr_valid = 0;
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 6'h2A, 1'b1, 1'b0, 7'h00};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 6'h2A, 1'b1, 1'b0, 7'h00};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 6'h2A, 1'b0, 1'b1, 7'h2A};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 6'h15, 1'b0, 1'b1, 7'h15};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 6'h3F, 1'b0, 1'b1, 7'h3F};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 6'h00, 1'b0, 1'b1, 7'h00};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 6'h3F, 1'b1, 1'b0, 7'h00};

    @(posedge clk);
    model_update();
    @(negedge clk);

    // Reset state and the first instruction.
    step();
    #1 chk("reset_outputs", 32'(dut_out()), 32'h0);
    reset = 0;
    start_and_fetch();
    step(); step();
    issue();
    #1 chk("first_exec_inc", 32'({pc_inc, pc_load}), 32'b10);
    step();
    chk("first_retired", 32'(retired), 32'd1);
    chk("refetch_after_exec", 32'({fetch_req, pc_inc}), 32'b10);

    // Branch decode table.
    for (int i = 0; i < 7; i++) begin
      issue();
      dec_br_zero = vecs[i].brz; dec_br_always = vecs[i].bra;
      zero = vecs[i].zf; dec_target = vecs[i].tgt;
      #1 chk($sformatf("table_%0d", i), 32'({pc_inc, pc_load, pc_target}),
             32'({vecs[i].exp_inc, vecs[i].exp_load, vecs[i].exp_tgt}));
      step();
      clear_dec();
    end

`ifndef CALL_STACK_EN
    issue();
    dec_ret = 1;
    #1 chk("ret_ignored", 32'({pc_inc, pc_load}), 32'b10);
    step(); clear_dec();
    issue();
    dec_call = 1; dec_target = 6'h11;
    #1 chk("call_as_branch", 32'({pc_inc, pc_load, pc_target}), 32'({2'b01, 7'h11}));
    step(); clear_dec();
`endif

    // Fetch timeout boundary: valid on the last allowed cycle still wins.
    do_reset();
    start_and_fetch();
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    chk("no_err_before_timeout", 32'({err, fetch_req}), 32'b01);
    issue();
    chk("valid_on_timeout_cycle", 32'({err, fetch_req}), 32'b00);
    step();
    for (int i = 0; i < TIMEOUT; i++) step();
    chk("timeout_err", 32'({err, fetch_req}), 32'b10);
    start = 1; instr_valid = 1; dec_br_always = 1;
    step(); step();
    chk("err_sticky_no_strobe", 32'({err, fetch_req, pc_inc, pc_load}), 32'b1000);
    start = 0; instr_valid = 0; clear_dec();
    do_reset();
    chk("reset_clears_err", 32'(dut_out()), 32'h0);

    // Halt wins over a branch and parks the FSM.
    start_and_fetch();
    issue();
    dec_halt = 1; dec_br_always = 1; dec_target = 6'h0C;
    #1 chk("halt_no_strobe", 32'({pc_inc, pc_load, pc_target}), 32'h0);
    step(); clear_dec();
    chk("halted_retired", 32'({halted, retired}), 32'({1'b1, 16'd1}));
    start = 1; instr_valid = 1;
    step(); step(); step();
    start = 0; instr_valid = 0;
    chk("halted_ignores_start", 32'({halted, fetch_req, retired}), 32'({2'b10, 16'd1}));

`ifdef CALL_STACK_EN
    do_reset();
    start_and_fetch();
    issue();
    pc = 7'h7F; dec_call = 1; dec_target = 6'h05;
    #1 chk("call_load", 32'({pc_load, pc_target}), 32'({1'b1, 7'h05}));
    step(); clear_dec();
    issue();
    dec_ret = 1;
    #1 chk("ret_wraps_to_zero", 32'({pc_load, pc_target}), 32'({1'b1, 7'h00}));
    step(); clear_dec();
    for (int i = 0; i < STACK_DEPTH; i++) begin
      issue(); pc = 7'(i); dec_call = 1; dec_target = 6'(i + 8); step(); clear_dec();
    end
    issue();
    dec_call = 1;
    #1 chk("overflow_no_strobe", 32'({pc_inc, pc_load}), 32'b00);
    step(); clear_dec();
    chk("overflow_err", 32'({err, retired}), 32'({1'b1, 16'd6}));
    do_reset();
    start_and_fetch();
    issue();
    dec_ret = 1;
    #1 chk("underflow_no_strobe", 32'({pc_inc, pc_load}), 32'b00);
    step(); clear_dec();
    chk("underflow_err", 32'({err, retired}), 32'({1'b1, 16'd0}));
`endif

    // Reset while a fetch is outstanding.
    do_reset();
    start_and_fetch();
    issue();
    step();
    chk("pre_reset_fetch", 32'({fetch_req, retired}), 32'({1'b1, 16'd1}));
    reset = 1;
    step();
    reset = 0;
    chk("reset_mid_fetch", 32'(dut_out()), 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      reset       = ($urandom_range(0, 99) < ((m_phase >= P_HALTED) ? 25 : 2));
      start       = ($urandom_range(0, 3) == 0);
      instr_valid = ($urandom_range(0, 2) == 0);
      pc          = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 3) == 0) pc = 7'h7F;
      dec_halt      = ($urandom_range(0, 15) == 0);
      dec_br_zero   = ($urandom_range(0, 3) == 0);
      dec_br_always = ($urandom_range(0, 4) == 0);
      dec_call      = ($urandom_range(0, 3) == 0);
      dec_ret       = ($urandom_range(0, 3) == 0);
      zero          = ($urandom_range(0, 1) == 0);
      dec_target    = 6'($urandom_range(0, 63));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle control FSM for the program-counter register of the small accumulator core.
- Issues instruction fetches and waits on the instruction-memory handshake.
- Samples decoded control in a single EXEC cycle and drives increment/load strobes plus a load target to the PC register.
- Also tracks retired instructions and flags fetch timeouts; an optional return-address stack supports call/return.

Parameters:
PC_W, 7, PC width.
TGT_W, 6, branch target width; zero-extended to PC_W.
TIMEOUT, 16, max cycles in FETCH without instr_valid before ERROR (>=2).
STACK_DEPTH, 4, return-address stack entries (used only with CALL_STACK_EN).

Ports:
clk  in  1  clock, all state updates on posedge.
reset  in  1  synchronous, active-high.
start  in  1  begin execution from IDLE.
pc  in  PC_W  current PC register value.
instr_valid  in  1  instruction memory response for the outstanding fetch.
dec_halt  in  1  decoded HALT.
dec_br_zero  in  1  decoded branch-if-zero.
dec_br_always  in  1  decoded unconditional branch.
dec_call  in  1  decoded call.
dec_ret  in  1  decoded return.
zero  in  1  ALU zero flag.
dec_target  in  TGT_W  branch/call target.
fetch_req  out  1  fetch outstanding.
pc_inc  out  1  PC <= PC+1 at end of this cycle.
pc_load  out  1  PC <= pc_target at end of this cycle.
pc_target  out  PC_W  load value.
halted  out  1  in HALTED.
err  out  1  in ERROR (sticky).
retired  out  16  retired-instruction count, saturating at 16'hFFFF.

Behaviour:
- Reset: state IDLE; all outputs 0; retired=0; timeout counter=0; stack emptied. Reset mid-operation aborts any fetch without a further strobe.
- States: IDLE, FETCH, EXEC, HALTED, ERROR.
- IDLE:
  - start=1 -> FETCH next cycle.
  - No strobes in IDLE.
  - start in any other state is ignored.
- FETCH:
  - fetch_req=1 (Moore).
  - instr_valid=1 -> EXEC next cycle; counter cleared.
  - Otherwise counter increments; when counter reaches TIMEOUT-1 with instr_valid=0 -> ERROR.
  - instr_valid=1 on the timeout cycle wins (goes to EXEC).
  - instr_valid outside FETCH is ignored.
- EXEC: exactly one cycle. Strobes are combinational from decoded inputs. Priority:
  1. dec_halt: no strobe -> HALTED; instruction counts as retired.
  2. dec_ret: pc_load=1, pc_target=popped entry.
  3. dec_call: pc_load=1, pc_target=zero-extended dec_target; push (pc+1) mod 2^PC_W, so 127 wraps to 0.
  4. dec_br_always, or dec_br_zero with zero=1: pc_load=1, pc_target=zero-extended dec_target.
  5. Otherwise pc_inc=1; PC wraps naturally in the PC register.
- EXEC exit: -> FETCH unless halting or erroring. retired increments by 1, saturating.
- pc_inc and pc_load are never both 1.
- pc_target=0 whenever pc_load=0.
- HALTED: halted=1, no strobes, no fetches; exits only on reset.
- ERROR: err=1, no strobes, no fetches; exits only on reset.

Optional Feature:
CALL_STACK_EN
- Defined:
  - LIFO of STACK_DEPTH x PC_W entries.
  - Push on full or pop on empty -> ERROR; no strobe that cycle; retired not incremented.
  - Simultaneous dec_call and dec_ret: ret wins per priority; no push.
- Undefined:
  - No storage.
  - dec_call behaves as dec_br_always.
  - dec_ret is ignored: falls through to the lower-priority rows, so pc_inc=1 unless a branch is decoded.
  - Stack errors are impossible.

Test Plan:
- Reset then start=1; instr_valid 2 cycles after FETCH entry; no control decoded -> pc_inc=1 for exactly one cycle; retired=1; fetch_req re-asserts next cycle.
- EXEC with dec_br_zero=1, zero=0, dec_target=6'h2A -> pc_inc=1. Repeat with zero=1 -> pc_load=1, pc_target=7'h2A.
- Hold instr_valid=0 for TIMEOUT=16 cycles in FETCH -> err=1 on the cycle after the 16th wait; no strobes afterwards. Reset clears err and returns to IDLE.
- dec_halt=1 together with dec_br_always=1 -> no strobe; halted=1 next cycle; retired incremented; start is ignored thereafter.
- CALL_STACK_EN, STACK_DEPTH=4, pc=7'h7F:
  - Call to target 6'h05 -> pc_load=1, pc_target=7'h05.
  - Later ret -> pc_load=1, pc_target=7'h00.
  - Five nested calls -> err=1 on the fifth.
  - Ret on empty stack -> err=1.
- Assert reset while in FETCH with fetch_req=1 -> next cycle state IDLE, all outputs 0, retired=0.
